// File: rtl/dep_matrix_sched_pkg.sv
// Shared constants and helpers for the dependency-matrix scheduler.
package sched_pkg;
  localparam int DEF_BS      = 16;
  localparam int DEF_ISSUE_W = 2;
  localparam int DEF_CMPL_W  = 2;
  localparam int MAX_BS      = 1024;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Caller slices the low BS bits.
  function automatic logic [MAX_BS-1:0] onehot(input int unsigned i);
    return MAX_BS'(1) << i;
  endfunction
endpackage

// File: rtl/dep_matrix_sched_pick.sv
// First-W-set-bits picker: port p receives the (p+1)-th lowest set bit of vec.
module prio_pick_n
  import sched_pkg::*;
#(
  parameter int N = DEF_BS,
  parameter int W = DEF_ISSUE_W,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]    vec,
  output logic [W-1:0]    valid,
  output logic [W*IW-1:0] idx
);
  logic [N-1:0] rem;
  logic         found;

  always_comb begin
    rem   = vec;
    valid = '0;
    idx   = '0;
    found = 1'b0;
    for (int p = 0; p < W; p++) begin
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!found && rem[i]) begin
          found            = 1'b1;
          valid[p]         = 1'b1;
          idx[p*IW +: IW]  = IW'(i);
          rem[i]           = 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/dep_matrix_sched.sv
// Dependency-matrix scheduler: per-entry wait rows, column-clear wakeup,
// lowest-index multi-port issue select, flush and occupancy tracking.
module dep_matrix_sched
  import sched_pkg::*;
#(
  parameter int BS      = DEF_BS,
  parameter int ISSUE_W = DEF_ISSUE_W,
  parameter int CMPL_W  = DEF_CMPL_W,
  localparam int IW = idx_w(BS),
  localparam int OW = idx_w(BS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  input  logic [IW-1:0]        alloc_idx,
  input  logic [BS-1:0]        alloc_deps,
  input  logic [CMPL_W-1:0]    cmpl_valid,
  input  logic [CMPL_W*IW-1:0] cmpl_idx,
  input  logic [ISSUE_W-1:0]   issue_en,
  input  logic                 flush,
  output logic [ISSUE_W-1:0]   issue_valid,
  output logic [ISSUE_W*IW-1:0] issue_idx,
  output logic [BS-1:0]        ready_vec,
  output logic [OW-1:0]        occupancy,
  output logic                 full,
  output logic                 empty,
  output logic                 err_overwrite
);
  logic [BS-1:0][BS-1:0] row_q, row_d;
  logic [BS-1:0]         valid_q, valid_d, issued_q, issued_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic                  err_q, err_d;
  logic [BS-1:0]         cmpl_mask, alloc_oh, acc_mask;
  int                    n_done, occ_sum;

  function automatic logic [BS-1:0] oh(input logic [IW-1:0] i);
    logic [MAX_BS-1:0] w;
    w = onehot(32'(i));
    return w[BS-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < BS; i++)
      ready_vec[i] = valid_q[i] & ~issued_q[i] & ~|row_q[i];
  end

  prio_pick_n #(.N(BS), .W(ISSUE_W)) u_pick (
    .vec   (ready_vec),
    .valid (issue_valid),
    .idx   (issue_idx)
  );

  always_comb begin
    cmpl_mask = '0;
    for (int p = 0; p < CMPL_W; p++)
      if (cmpl_valid[p]) cmpl_mask |= oh(cmpl_idx[p*IW +: IW]);
    alloc_oh = alloc_valid ? oh(alloc_idx) : '0;
    acc_mask = '0;
    for (int p = 0; p < ISSUE_W; p++)
      if (issue_valid[p] && issue_en[p]) acc_mask |= oh(issue_idx[p*IW +: IW]);

    // Alloc beats completion on the same entry; completion beats issue.
    valid_d  = (valid_q & ~cmpl_mask) | alloc_oh;
    issued_d = (issued_q | acc_mask) & ~cmpl_mask & ~alloc_oh;
    for (int i = 0; i < BS; i++)
      row_d[i] = alloc_oh[i] ? (alloc_deps & ~cmpl_mask & ~alloc_oh)
                             : (row_q[i] & ~cmpl_mask);

    // Duplicate completion ports collapse in the mask, so each entry counts once.
    n_done = 0;
    for (int i = 0; i < BS; i++)
      n_done += int'(cmpl_mask[i] & valid_q[i] & ~alloc_oh[i]);
    occ_sum = int'(occ_q) + int'(|(alloc_oh & ~valid_q)) - n_done;
    if (occ_sum < 0)  occ_sum = 0;
    if (occ_sum > BS) occ_sum = BS;
    occ_d = OW'(occ_sum);

    err_d = err_q | (|(alloc_oh & valid_q & ~cmpl_mask));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_q    <= '0;
      valid_q  <= '0;
      issued_q <= '0;
      occ_q    <= '0;
      err_q    <= 1'b0;
    end else if (flush) begin
      row_q    <= '0;
      valid_q  <= '0;
      issued_q <= '0;
      occ_q    <= '0;
    end else begin
      row_q    <= row_d;
      valid_q  <= valid_d;
      issued_q <= issued_d;
      occ_q    <= occ_d;
      err_q    <= err_d;
    end
  end

  assign occupancy     = occ_q;
  assign full          = (occ_q == OW'(BS));
  assign empty         = (occ_q == '0);
  assign err_overwrite = err_q;
endmodule

// File: tb/tb_dep_matrix_sched.sv
// Scoreboard bench: a set-based reference model predicts each cycle's outputs.
module tb_dep_matrix_sched;
  import sched_pkg::*;
  localparam int BS = 16, ISSUE_W = 2, CMPL_W = 2, IW = 4, OW = 5;

  logic                    clk = 1'b0, rst = 1'b0, alloc_valid = 1'b0, flush = 1'b0;
  logic [IW-1:0]           alloc_idx = '0;
  logic [BS-1:0]           alloc_deps = '0;
  logic [CMPL_W-1:0]       cmpl_valid = '0;
  logic [CMPL_W*IW-1:0]    cmpl_idx = '0;
  logic [ISSUE_W-1:0]      issue_en = '0;
  logic [ISSUE_W-1:0]      issue_valid;
  logic [ISSUE_W*IW-1:0]   issue_idx;
  logic [BS-1:0]           ready_vec;
  logic [OW-1:0]           occupancy;
  logic                    full, empty, err_overwrite;

  always #5 clk = ~clk;

  dep_matrix_sched #(.BS(BS), .ISSUE_W(ISSUE_W), .CMPL_W(CMPL_W)) dut (
    .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
    .alloc_deps(alloc_deps), .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx),
    .issue_en(issue_en), .flush(flush), .issue_valid(issue_valid),
    .issue_idx(issue_idx), .ready_vec(ready_vec), .occupancy(occupancy),
    .full(full), .empty(empty), .err_overwrite(err_overwrite)
  );

  typedef struct {
    logic [ISSUE_W-1:0]    iv;
    logic [ISSUE_W*IW-1:0] iidx;
    logic [BS-1:0]         rv;
    int                    occ;
    logic                  err;
  } exp_t;
  exp_t sbq[$];
  int n_chk = 0, n_pass = 0;

  bit m_valid[BS], m_issued[BS], m_wait[BS][BS], m_err, m_known;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit m_ready(int i);
    bit r;
    r = m_valid[i] && !m_issued[i];
    for (int j = 0; j < BS; j++) if (m_wait[i][j]) r = 0;
    return r;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    int k;
    e.iv = '0; e.iidx = '0; e.rv = '0; e.occ = 0; e.err = m_err;
    k = 0;
    for (int i = 0; i < BS; i++) begin
      if (m_valid[i]) e.occ++;
      if (m_ready(i)) begin
        e.rv[i] = 1'b1;
        if (k < ISSUE_W) begin
          e.iv[k] = 1'b1;
          e.iidx[k*IW +: IW] = IW'(i);
        end
        k++;
      end
    end
    return e;
  endfunction

  function automatic void m_clear(bit all);
    for (int i = 0; i < BS; i++) begin
      m_valid[i] = 0; m_issued[i] = 0;
      for (int j = 0; j < BS; j++) m_wait[i][j] = 0;
    end
    if (all) m_err = 0;
  endfunction

  function automatic void m_update(bit r, bit av, int ai, logic [BS-1:0] ad,
                                   logic [CMPL_W-1:0] cv, logic [CMPL_W*IW-1:0] ci,
                                   logic [ISSUE_W-1:0] ie, bit fl);
    bit cset[BS], acc[BS], pre[BS];
    int k;
    if (!r) begin m_clear(1); m_known = 1; return; end
    if (fl) begin m_clear(0); return; end
    for (int i = 0; i < BS; i++) begin cset[i] = 0; acc[i] = 0; pre[i] = m_valid[i]; end
    for (int p = 0; p < CMPL_W; p++) if (cv[p]) cset[int'(ci[p*IW +: IW])] = 1;
    k = 0;
    for (int i = 0; i < BS; i++)
      if (m_ready(i)) begin
        if (k < ISSUE_W && ie[k]) acc[i] = 1;
        k++;
      end
    for (int i = 0; i < BS; i++) if (acc[i]) m_issued[i] = 1;
    for (int j = 0; j < BS; j++)
      if (cset[j]) begin
        for (int i = 0; i < BS; i++) m_wait[i][j] = 0;
        m_valid[j] = 0; m_issued[j] = 0;
      end
    if (av) begin
      if (pre[ai] && !cset[ai]) m_err = 1;
      for (int j = 0; j < BS; j++) m_wait[ai][j] = ad[j] && !cset[j] && (j != ai);
      m_valid[ai] = 1; m_issued[ai] = 0;
    end
  endfunction

  task automatic step(bit r, bit av, int ai, logic [BS-1:0] ad, logic [CMPL_W-1:0] cv,
                      logic [CMPL_W*IW-1:0] ci, logic [ISSUE_W-1:0] ie, bit fl);
    if (m_known) sbq.push_back(predict());
    rst = r; alloc_valid = av; alloc_idx = IW'(ai); alloc_deps = ad;
    cmpl_valid = cv; cmpl_idx = ci; issue_en = ie; flush = fl;
    m_update(r, av, ai, ad, cv, ci, ie, fl);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one prediction per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    logic [ISSUE_W*IW-1:0] msk;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        msk = '0;
        for (int p = 0; p < ISSUE_W; p++) if (e.iv[p]) msk[p*IW +: IW] = '1;
        check("ready_vec", ready_vec, e.rv);
        check("issue", {issue_valid, issue_idx & msk}, {e.iv, e.iidx});
        check("occ_full_empty", {occupancy, full, empty},
              {OW'(e.occ), e.occ == BS, e.occ == 0});
        check("err_overwrite", err_overwrite, e.err);
      end
    end
  end

  initial begin
    m_known = 0; m_err = 0;
    for (int c = 0; c < 2; c++)
      step(0, 1'($urandom), $urandom_range(0, BS-1), BS'($urandom), CMPL_W'($urandom),
           (CMPL_W*IW)'($urandom), ISSUE_W'($urandom), 1'($urandom));
    check("rst_issue_valid", issue_valid, 0);
    check("rst_occ_empty_err", {occupancy, empty, err_overwrite}, {5'd0, 1'b1, 1'b0});

    step(1, 1, 3, '0, '0, '0, '0, 0);
    step(1, 1, 5, '0, '0, '0, '0, 0);
    check("two_ready_issue", {issue_valid, issue_idx}, {2'b11, 4'd5, 4'd3});
    check("two_ready_vec", ready_vec, 16'h0028);
    check("two_ready_occ", occupancy, 2);

    step(1, 1, 7, 16'h0008, '0, '0, '0, 0);
    check("wait7_blocked", {ready_vec[7], occupancy}, {1'b0, 5'd3});
    step(1, 0, 0, '0, 2'b01, {4'd0, 4'd3}, '0, 0);
    check("wait7_woken", {ready_vec[7], occupancy}, {1'b1, 5'd2});

    step(1, 1, 9, 16'h0004, 2'b01, {4'd0, 4'd2}, '0, 0);
    check("bypass9_ready", {ready_vec[9], occupancy}, {1'b1, 5'd3});

    step(1, 0, 0, '0, '0, '0, '0, 1);
    check("flush_occ", occupancy, 0);
    step(1, 1, 1, '0, '0, '0, '0, 0);
    step(1, 1, 4, '0, '0, '0, '0, 0);
    step(1, 1, 6, '0, '0, '0, '0, 0);
    step(1, 0, 0, '0, '0, '0, 2'b01, 0);
    check("partial_accept_issue", {issue_valid, issue_idx}, {2'b11, 4'd6, 4'd4});
    check("partial_accept_rv1", ready_vec[1], 0);
    check("partial_accept_occ", occupancy, 3);

    step(1, 0, 0, '0, '0, '0, '0, 1);
    for (int i = 0; i < BS; i++) step(1, 1, i, '0, '0, '0, '0, 0);
    check("fill_full", {full, occupancy}, {1'b1, 5'd16});
    step(1, 1, 0, '0, '0, '0, '0, 0);
    check("overwrite_err", {err_overwrite, occupancy}, {1'b1, 5'd16});
    step(1, 0, 0, '0, '0, '0, '0, 1);
    check("flush_keeps_err", {occupancy, empty, err_overwrite}, {5'd0, 1'b1, 1'b1});

    for (int c = 0; c < 800; c++)
      step($urandom_range(0, 299) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, BS-1), BS'($urandom & $urandom & $urandom),
           CMPL_W'($urandom), (CMPL_W*IW)'($urandom), ISSUE_W'($urandom),
           $urandom_range(0, 59) == 0);
    step(1, 0, 0, '0, '0, '0, '0, 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dep_matrix_sched.md
Name: dep_matrix_sched

Overview:
- Parametrised dependency-matrix scheduler for the out-of-order execution buffer.
- Each of BS buffer entries owns one row; bit j in row i set = entry i waits on producer entry j.
- Adds per-entry valid/issued state, multi-port completion wakeup (column clear), multi-port lowest-index issue select, flush and occupancy tracking.

Parameters:
- BS, 16, number of buffer entries (rows = columns); power of two, >= 4
- ISSUE_W, 2, issue (select) ports per cycle, 1..4
- CMPL_W, 2, completion (wakeup) ports per cycle, 1..4
- IW (localparam), $clog2(BS), entry index width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- alloc_valid  in  1  write a new entry this cycle
- alloc_idx  in  IW  entry being written
- alloc_deps  in  BS  dependency row of the new entry
- cmpl_valid  in  CMPL_W  completion strobe per port
- cmpl_idx  in  CMPL_W*IW  completing entry per port, port p at [p*IW +: IW]
- issue_en  in  ISSUE_W  downstream accepts port p this cycle
- flush  in  1  drop all entries
- issue_valid  out  ISSUE_W  port p presents a ready entry
- issue_idx  out  ISSUE_W*IW  entry presented on port p
- ready_vec  out  BS  per-entry ready (valid & ~issued & row == 0)
- occupancy  out  $clog2(BS+1)  number of valid entries
- full  out  1  occupancy == BS
- empty  out  1  occupancy == 0
- err_overwrite  out  1  sticky: alloc hit an already-valid entry

Behaviour:
- Reset (rst == 0 at a clk edge): all rows = 0, valid = 0, issued = 0, occupancy = 0, err_overwrite = 0. Consequently issue_valid = 0, ready_vec = 0, empty = 1, full = 0. Reset overrides every other input in that cycle.
- Alloc: row[alloc_idx] <= alloc_deps & ~cmpl_mask & ~(1 << alloc_idx); valid = 1, issued = 0. cmpl_mask = OR of one-hot(cmpl_idx[p]) over all p with cmpl_valid[p]. A self-dependency bit is always dropped.
- Completion, port p valid: column cmpl_idx[p] cleared in every row; entry cmpl_idx[p] gets valid = 0, issued = 0. Completion of a non-valid entry only clears the column; no error is raised.
- Alloc and completion on the same idx in one cycle: alloc wins (entry valid, new row). The column is still cleared in all other rows. occupancy is unchanged.
- Latency:
  - alloc at edge t with resulting row == 0 -> ready_vec bit high after edge t.
  - completion at edge t -> dependents see the column cleared after edge t.
- Select (combinational from registered state): port 0 gets the lowest-index ready entry, port 1 the next lowest, and so on. issue_valid[p] = 0 when fewer than p+1 entries are ready.
- Handshake: issue_valid[p] & issue_en[p] at an edge -> that entry's issued = 1, and it leaves ready_vec next cycle. An entry not accepted stays presented; issue_en with issue_valid low is ignored.
- Issued entries stay valid, and keep counting in occupancy, until completion.
- flush: valid = 0, issued = 0, rows = 0, occupancy = 0 next cycle. Alloc/issue/completion in the same cycle are ignored. err_overwrite is retained.
- Occupancy next = occupancy + alloc_new − completions of valid entries, where:
  - alloc_new counts only an alloc to a non-valid entry;
  - duplicate cmpl_idx across ports counts once.
- occupancy saturates at 0..BS. full/empty are decoded from the registered occupancy.
- Alloc into a valid entry (not simultaneously completing): row overwritten, err_overwrite <= 1 (sticky until reset), occupancy unchanged.

Decomposition:
- Package sched_pkg:
  - index-width function;
  - one-hot decode function;
  - default BS/ISSUE_W/CMPL_W constants.
- Sub-module prio_pick_n: parametrised first-N-set-bits picker over a BS-bit vector, returning ISSUE_W valid/index pairs. The top-level instantiates it once.

Test Plan:
- Reset: hold rst = 0 two cycles with random inputs -> issue_valid = 0, occupancy = 0, empty = 1, err_overwrite = 0.
- Alloc idx 3, deps 0, then idx 5, deps 0, issue_en = 2'b00 -> next cycle issue_valid = 2'b11, issue_idx = {5, 3}, ready_vec = 0x0028, occupancy = 2.
- Alloc idx 7 with deps bit 3 set; complete 3 one cycle later -> ready_vec[7] low until the cycle after completion, then high; occupancy goes 3 -> 2.
- Alloc idx 9 with deps = bit 2, in the same cycle as completion of idx 2 -> row 9 stored as 0, ready_vec[9] = 1 one cycle later.
- Entries 1, 4, 6 ready, ISSUE_W = 2, issue_en = 2'b01 -> next cycle ports show {6, 4}; entry 1 no longer in ready_vec; occupancy still 3.
- Fill all 16 entries -> full = 1. Re-alloc idx 0 -> err_overwrite = 1, occupancy = 16. flush -> occupancy = 0, empty = 1, err_overwrite remains 1.
